// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: op codes, FSM states, datapath width.
// Optional multiplier is controlled by the ALU_MUL_EN macro (see alu_iter).
package alu_pkg;

  localparam int ALU_W   = 64;
  localparam int ALU_OPW = 4;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/alu_iter_comb.sv
// Single-cycle ALU operations. Shifts, MUL and undefined codes yield zero here;
// the iterative engine in alu_iter handles shifts and multiply.
module alu_comb
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   y
);

  always_comb begin
    // NOTE: y gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLT:  y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: y = {{(W-1){1'b0}}, (a < b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle ops via alu_comb, bit-serial shifts, and an optional
// shift-add multiplier built only when ALU_MUL_EN is defined.
module alu_iter
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int OPW = ALU_OPW
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [OPW-1:0] op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   result,
  output logic           zero,
  output logic           busy,
  output logic           done
);

  localparam int CNT_W = $clog2(W);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [OPW-1:0]   r_op;
  logic [W-1:0]     r_work;
  logic [W-1:0]     r_result;

  logic [W-1:0]     w_comb_y;
  logic [W-1:0]     w_sc_result;
  logic [W-1:0]     w_shift_step;
  logic [CNT_W-1:0] w_shamt;
  logic             w_is_shift;
  logic             w_is_mul;
  logic             w_go_shift;

  alu_comb #(.W(W), .OPW(OPW)) u_comb (
    .op (op),
    .a  (a),
    .b  (b),
    .y  (w_comb_y)
  );

  assign w_shamt     = b[CNT_W-1:0];
  assign w_is_shift  = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign w_go_shift  = w_is_shift && (w_shamt != '0);
  // A zero-length shift finishes like a single-cycle op and returns a unchanged.
  assign w_sc_result = w_is_shift ? a : w_comb_y;

`ifdef ALU_MUL_EN
  logic [W-1:0] r_mr;
  logic [W-1:0] r_acc;
  logic [W-1:0] w_acc_nxt;

  assign w_is_mul  = (op == OP_MUL);
  assign w_acc_nxt = r_mr[0] ? (r_acc + r_work) : r_acc;
`else
  assign w_is_mul  = 1'b0;
`endif

  always_comb begin
    w_shift_step = r_work;
    case (r_op)
      OP_SLL:  w_shift_step = {r_work[W-2:0], 1'b0};
      OP_SRL:  w_shift_step = {1'b0, r_work[W-1:1]};
      OP_SRA:  w_shift_step = {r_work[W-1], r_work[W-1:1]};
      default: w_shift_step = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_FIN);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_go_shift)    w_state_nxt = S_SHIFT;
          else if (w_is_mul) w_state_nxt = S_MUL;
          else               w_state_nxt = S_FIN;
        end
      end
      S_SHIFT: if (r_cnt == '0) w_state_nxt = S_FIN;
`ifdef ALU_MUL_EN
      S_MUL:   if (r_cnt == '0) w_state_nxt = S_FIN;
`endif
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_work   <= '0;
      r_result <= '0;
`ifdef ALU_MUL_EN
      r_mr     <= '0;
      r_acc    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op   <= op;
            r_work <= a;
            // Counter holds iterations remaining minus one; the last step sees zero.
            r_cnt  <= w_go_shift ? (w_shamt - CNT_W'(1)) : '1;
`ifdef ALU_MUL_EN
            r_mr   <= b;
            r_acc  <= '0;
`endif
            if (!w_go_shift && !w_is_mul) r_result <= w_sc_result;
          end
        end
        S_SHIFT: begin
          r_work <= w_shift_step;
          if (r_cnt == '0) r_result <= w_shift_step;
          else             r_cnt    <= r_cnt - CNT_W'(1);
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          r_acc  <= w_acc_nxt;
          r_work <= {r_work[W-2:0], 1'b0};
          r_mr   <= {1'b0, r_mr[W-1:1]};
          if (r_cnt == '0) r_result <= w_acc_nxt;
          else             r_cnt    <= r_cnt - CNT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign zero   = (r_result == '0);

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter; expectations follow ALU_MUL_EN if defined.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W       = 64;
  localparam int LAT_MAX = 200;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  alu_iter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    int           lat;
    string        name;
  } vec_t;

  // Drives one request; lat = 1 means done seen in the cycle right after accept.
  task automatic issue(input logic [3:0] i_op, input logic [W-1:0] i_a,
                       input logic [W-1:0] i_b, output int lat);
    op = i_op; a = i_a; b = i_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < LAT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic run_vectors(input vec_t v[]);
    int lat;
    foreach (v[i]) begin
      issue(v[i].op, v[i].a, v[i].b, lat);
      checks++;
      if (lat !== v[i].lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
      checks++;
      if (result !== v[i].y) begin
        errors++;
        $display("FAIL %s result: got %h expected %h", v[i].name, result, v[i].y);
      end
      checks++;
      if (zero !== (v[i].y == '0)) begin
        errors++;
        $display("FAIL %s zero: got %b expected %b", v[i].name, zero, (v[i].y == '0));
      end
      next_cycle();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || result !== v[i].y) begin
        errors++;
        $display("FAIL %s after-done: done=%b busy=%b result=%h expected 0/0/%h",
                 v[i].name, done, busy, result, v[i].y);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) next_cycle();
    checks++;
    if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h zero=%b busy=%b done=%b expected 0/1/0/0",
               result, zero, busy, done);
    end
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_single_cycle();
    vec_t v[];
    v = new[11];
    v[0]  = '{4'd0,  64'd5,   64'd4,   64'd9,   1, "add_5_4"};
    v[1]  = '{4'd1,  64'd7,   64'd7,   64'd0,   1, "sub_7_7"};
    v[2]  = '{4'd5,  '1,      64'd1,   64'd1,   1, "slt_m1_1"};
    v[3]  = '{4'd6,  '1,      64'd1,   64'd0,   1, "sltu_m1_1"};
    v[4]  = '{4'd0,  '1,      64'd1,   64'd0,   1, "add_wrap"};
    v[5]  = '{4'd2,  64'hF0F0, 64'hFF00, 64'hF000, 1, "and"};
    v[6]  = '{4'd3,  64'hF0F0, 64'h0F0F, 64'hFFFF, 1, "or"};
    v[7]  = '{4'd4,  64'hFFFF, 64'h0F0F, 64'hF0F0, 1, "xor"};
    v[8]  = '{4'd1,  64'd0,   64'd1,   '1,      1, "sub_wrap"};
    v[9]  = '{4'd5,  64'd1,   '1,      64'd0,   1, "slt_1_m1"};
    v[10] = '{4'd15, 64'd5,   64'd4,   64'd0,   1, "undef_op"};
    run_vectors(v);
  endtask

  task automatic test_shift();
    vec_t v[];
    v = new[6];
    v[0] = '{4'd9, 64'h8000_0000_0000_0000, 64'd4,  64'hF800_0000_0000_0000, 5,  "sra_4"};
    v[1] = '{4'd7, 64'h1234_5678_9ABC_DEF0, 64'd0,  64'h1234_5678_9ABC_DEF0, 1,  "sll_0"};
    v[2] = '{4'd8, 64'h8000_0000_0000_00F0, 64'd4,  64'h0800_0000_0000_000F, 5,  "srl_4"};
    v[3] = '{4'd7, 64'd1,                   64'd63, 64'h8000_0000_0000_0000, 64, "sll_63"};
    v[4] = '{4'd7, 64'd3,                   64'h41, 64'd6,                   2,  "sll_shamt_low_bits"};
    v[5] = '{4'd9, 64'h0000_0000_0000_0010, 64'd8,  64'd0,                   9,  "sra_pos_to_zero"};
    run_vectors(v);
  endtask

  task automatic test_mul();
    vec_t v[];
    v = new[2];
`ifdef ALU_MUL_EN
    v[0] = '{4'd10, 64'd3, '1,    64'hFFFF_FFFF_FFFF_FFFD, 65, "mul_3_m1"};
    v[1] = '{4'd10, 64'd6, 64'd7, 64'd42,                  65, "mul_6_7"};
`else
    v[0] = '{4'd10, 64'd3, '1,    64'd0, 1, "mul_disabled_a"};
    v[1] = '{4'd10, 64'd6, 64'd7, 64'd0, 1, "mul_disabled_b"};
`endif
    run_vectors(v);
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    op = 4'd7; a = 64'd1; b = 64'd10; start = 1'b1;
    @(posedge clk); #1;
    // Keep requesting with different operands while the shift runs.
    op = 4'd0; a = 64'd5; b = 64'd5;
    for (int k = 1; k <= 11; k++) begin
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_busy T+%0d: got %b expected 1", k, busy);
      end
      if (done === 1'b1) done_cnt++;
      if (k == 11) begin
        checks++;
        if (result !== 64'h400) begin
          errors++;
          $display("FAIL b2b_result: got %h expected %h", result, 64'h400);
        end
      end
      next_cycle();
    end
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle T+12: busy=%b done=%b expected 0/0", busy, done);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 1", done_cnt);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    int lat;
    int done_seen = 0;
    issue(4'd0, 64'd5, 64'd4, lat);
    next_cycle();
`ifdef ALU_MUL_EN
    op = 4'd10; a = 64'd3; b = 64'd5;
`else
    op = 4'd7; a = 64'd3; b = 64'd40;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (done === 1'b1) done_seen++;
      if (k == 3) reset = 1'b1;
      if (k < 3) next_cycle();
    end
    next_cycle();
    checks++;
    if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: result=%h zero=%b busy=%b done=%b expected 0/1/0/0",
               result, zero, busy, done);
    end
    reset = 1'b0;
    for (int k = 0; k < 70; k++) begin
      next_cycle();
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d pulses expected 0", done_seen);
    end
    issue(4'd0, 64'd1, 64'd2, lat);
    checks++;
    if (lat !== 1 || result !== 64'd3) begin
      errors++;
      $display("FAIL reset_mid_add: latency=%0d result=%h expected 1/%h", lat, result, 64'd3);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_shift();
    test_mul();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
